// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: advance/hold/bubble driven by the global stall vector,
// flush kills contents; 1-cycle latency; saturating bubble/hold counters. No backpressure of its own.
module pipe_stage_reg #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int STAGE   = 1,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_delayslot,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_delayslot,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  generate
    if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic up;
  logic dn;
  logic bubble_ev;
  logic hold_ev;

  assign up        = stall[STAGE];
  assign dn        = stall[STAGE+1];
  assign bubble_ev = !flush && up && !dn;
  assign hold_ev   = !flush && up && dn;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_data      <= '0;
      out_delayslot <= 1'b0;
      bubble_cnt    <= '0;
      hold_cnt      <= '0;
    end else begin
      // Flush and bubble both insert the all-zero NOP; hold simply keeps contents.
      if (flush || (up && !dn)) begin
        out_valid     <= 1'b0;
        out_pc        <= '0;
        out_data      <= '0;
        out_delayslot <= 1'b0;
      end else if (!up) begin
        out_valid     <= in_valid;
        out_pc        <= in_pc;
        out_data      <= in_data;
        out_delayslot <= in_delayslot;
      end

      if (cnt_clr) begin
        bubble_cnt <= '0;
        hold_cnt   <= '0;
      end else begin
        if (bubble_ev && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
        if (hold_ev && hold_cnt != CNT_MAX)     hold_cnt   <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: STAGE=1/CNT_W=4 instance and a STAGE=3/DATA_W=64 instance on shared stimulus.
module tb_pipe_stage_reg;

  logic        Clk;
  logic        Rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic        cnt_clr;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic [63:0] in_data64;
  logic        in_delayslot;

  logic        a_valid, a_ds;
  logic [31:0] a_pc, a_data;
  logic [3:0]  a_bub, a_hold;

  logic        b_valid, b_ds;
  logic [31:0] b_pc;
  logic [63:0] b_data;
  logic [15:0] b_bub, b_hold;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.PC_W(32), .DATA_W(32), .STALL_W(6), .STAGE(1), .CNT_W(4)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data), .in_delayslot(in_delayslot),
    .out_valid(a_valid), .out_pc(a_pc), .out_data(a_data), .out_delayslot(a_ds),
    .bubble_cnt(a_bub), .hold_cnt(a_hold)
  );

  pipe_stage_reg #(.PC_W(32), .DATA_W(64), .STALL_W(6), .STAGE(3), .CNT_W(16)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data64), .in_delayslot(in_delayslot),
    .out_valid(b_valid), .out_pc(b_pc), .out_data(b_data), .out_delayslot(b_ds),
    .bubble_cnt(b_bub), .hold_cnt(b_hold)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n = 1'b0; stall = 6'b000000; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0000_0004; in_data = 32'h3401_1100;
    in_data64 = 64'h0; in_delayslot = 1'b1;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_valid", 64'(a_valid), 64'h0);
    chk("rst_pc",    64'(a_pc),    64'h0);
    chk("rst_data",  64'(a_data),  64'h0);
    chk("rst_ds",    64'(a_ds),    64'h0);
    chk("rst_bub",   64'(a_bub),   64'h0);
    chk("rst_hold",  64'(a_hold),  64'h0);

    // Advance after release
    Rst_n = 1'b1;
    tick();
    chk("adv_pc",    64'(a_pc),    64'h4);
    chk("adv_data",  64'(a_data),  64'h3401_1100);
    chk("adv_valid", 64'(a_valid), 64'h1);
    chk("adv_ds",    64'(a_ds),    64'h1);

    in_pc = 32'h8; in_delayslot = 1'b0;
    tick();
    chk("load8_pc", 64'(a_pc), 64'h8);

    // Hold three cycles while upstream changes
    in_pc = 32'hC; stall = 6'b000111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", 64'(a_pc), 64'h8);
    end
    chk("hold_cnt3", 64'(a_hold), 64'h3);
    chk("hold_bub0", 64'(a_bub),  64'h0);

    // Bubble
    in_pc = 32'h10; stall = 6'b000011;
    tick();
    chk("bub_valid", 64'(a_valid), 64'h0);
    chk("bub_pc",    64'(a_pc),    64'h0);
    chk("bub_data",  64'(a_data),  64'h0);
    chk("bub_cnt1",  64'(a_bub),   64'h1);
    chk("bub_hold3", 64'(a_hold),  64'h3);

    stall = 6'b000000;
    tick();
    chk("after_bub_pc", 64'(a_pc), 64'h10);

    in_pc = 32'h20;
    tick();
    chk("load20_pc", 64'(a_pc), 64'h20);

    // Flush overrides hold and is not counted
    stall = 6'b000111; flush = 1'b1;
    tick();
    chk("fl_hold_valid", 64'(a_valid), 64'h0);
    chk("fl_hold_pc",    64'(a_pc),    64'h0);
    chk("fl_hold_data",  64'(a_data),  64'h0);
    chk("fl_hold_hcnt",  64'(a_hold),  64'h3);
    chk("fl_hold_bcnt",  64'(a_bub),   64'h1);

    // Flush overrides advance
    stall = 6'b000000; in_valid = 1'b1; in_pc = 32'h24; in_delayslot = 1'b1;
    tick();
    chk("fl_adv_valid", 64'(a_valid), 64'h0);
    chk("fl_adv_pc",    64'(a_pc),    64'h0);
    chk("fl_adv_ds",    64'(a_ds),    64'h0);
    in_delayslot = 1'b0;

    // Saturation: 3 + 20 holds clamps at 15
    flush = 1'b0; stall = 6'b000111;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_hold", 64'(a_hold), 64'hF);
    tick();
    chk("sat_stay", 64'(a_hold), 64'hF);

    // Clear beats a simultaneous hold increment
    cnt_clr = 1'b1;
    tick();
    chk("clr_hold", 64'(a_hold), 64'h0);
    chk("clr_bub",  64'(a_bub),  64'h0);
    cnt_clr = 1'b0;

    // Reset mid-stall still clears the register
    stall = 6'b000000; in_pc = 32'h30;
    tick();
    chk("load30_pc", 64'(a_pc), 64'h30);
    stall = 6'b000111; Rst_n = 1'b0;
    tick();
    chk("rst_stall_pc",    64'(a_pc),    64'h0);
    chk("rst_stall_valid", 64'(a_valid), 64'h0);

    // STAGE=3 instance: stall[3]=0 advances
    Rst_n = 1'b1; stall = 6'b000111; in_pc = 32'h40;
    in_data64 = 64'hDEAD_BEEF_0123_4567;
    tick();
    chk("b_adv_data",  b_data,          64'hDEAD_BEEF_0123_4567);
    chk("b_adv_pc",    64'(b_pc),       64'h40);
    chk("b_adv_valid", 64'(b_valid),    64'h1);
    chk("a_post_rst_hold", 64'(a_hold), 64'h1);

    // stall[3]=1, stall[4]=1 holds
    stall = 6'b011000; in_data64 = 64'h1111_2222_3333_4444;
    tick();
    chk("b_hold_data", b_data,        64'hDEAD_BEEF_0123_4567);
    chk("b_hold_cnt",  64'(b_hold),   64'h1);

    // stall[3]=1, stall[4]=0 bubbles
    stall = 6'b001000;
    tick();
    chk("b_bub_valid", 64'(b_valid), 64'h0);
    chk("b_bub_data",  b_data,       64'h0);
    chk("b_bub_cnt",   64'(b_bub),   64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
